// File: rtl/reorder_buffer_if.sv
// Bundle of the dispatch, writeback, operand-lookup export and retire signals
// of the reorder buffer. The slave side is the buffer itself; the master side
// is the surrounding pipeline (decode/dispatch, writeback bus, register file).
interface reorder_buffer_if #(
  parameter int ID_SIZE          = 2,
  parameter int REG_ADDRESS_SIZE = 2,
  parameter int REGISTER_SIZE    = 32
);
  localparam int N_ENTRIES = 2 ** ID_SIZE;
  localparam int UW        = REG_ADDRESS_SIZE + 1 + ID_SIZE + 1;
  localparam int AW        = REGISTER_SIZE + UW;

  logic                                flush;
  logic                                alloc_valid;
  logic                                alloc_wr;
  logic [REG_ADDRESS_SIZE-1:0]         alloc_addr;
  logic                                alloc_ready;
  logic [ID_SIZE-1:0]                  tail;
  logic                                wb_valid;
  logic [ID_SIZE-1:0]                  wb_id;
  logic [REGISTER_SIZE-1:0]            wb_value;
  logic [N_ENTRIES-1:0][UW-1:0]        unavailable;
  logic [N_ENTRIES-1:0][AW-1:0]        available;
  logic                                commit_valid;
  logic                                commit_wr;
  logic [REG_ADDRESS_SIZE-1:0]         commit_addr;
  logic [REGISTER_SIZE-1:0]            commit_value;

  modport slave (
    input  flush, alloc_valid, alloc_wr, alloc_addr, wb_valid, wb_id, wb_value,
    output alloc_ready, tail, unavailable, available,
           commit_valid, commit_wr, commit_addr, commit_value
  );

  modport master (
    output flush, alloc_valid, alloc_wr, alloc_addr, wb_valid, wb_id, wb_value,
    input  alloc_ready, tail, unavailable, available,
           commit_valid, commit_wr, commit_addr, commit_value
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. Entries are allocated at tail on dispatch,
// marked done on writeback (in any order) and retired from head in program
// order, one per cycle. Pending and completed entries are exported as two
// slot-indexed arrays for operand lookup.
module reorder_buffer #(
  parameter int ID_SIZE          = 2,
  parameter int REG_ADDRESS_SIZE = 2,
  parameter int REGISTER_SIZE    = 32
) (
  input logic              clk,
  input logic              rst_n,
  reorder_buffer_if.slave  rob
);
  localparam int N_ENTRIES = 2 ** ID_SIZE;
  localparam int CW        = ID_SIZE + 1;

  logic [N_ENTRIES-1:0]                        busy;
  logic [N_ENTRIES-1:0]                        done;
  logic [N_ENTRIES-1:0]                        wr_q;
  logic [N_ENTRIES-1:0][REG_ADDRESS_SIZE-1:0]  addr_q;
  logic [N_ENTRIES-1:0][REGISTER_SIZE-1:0]     value_q;
  logic [ID_SIZE-1:0]                          head;
  logic [ID_SIZE-1:0]                          tail;
  logic [CW-1:0]                               count;

  logic full;
  logic empty;
  logic alloc_fire;
  logic commit_fire;
  logic wb_fire;

  assign full        = (count == CW'(N_ENTRIES));
  assign empty       = (count == '0);
  assign alloc_fire  = rob.alloc_valid && !full;
  // done is registered, so a head entry written back this cycle retires next cycle
  assign commit_fire = !empty && done[head];
  assign wb_fire     = rob.wb_valid && busy[rob.wb_id] && !done[rob.wb_id];

  assign rob.alloc_ready = !full;
  assign rob.tail        = tail;

  // Entry state, pointers, occupancy and registered retire outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy             <= '0;
      done             <= '0;
      wr_q             <= '0;
      addr_q           <= '0;
      value_q          <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      rob.commit_valid <= 1'b0;
      rob.commit_wr    <= 1'b0;
      rob.commit_addr  <= '0;
      rob.commit_value <= '0;
    end else if (rob.flush) begin
      busy             <= '0;
      done             <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      rob.commit_valid <= 1'b0;
    end else begin
      // alloc, writeback and commit always touch distinct entries on one edge:
      // alloc targets a free slot, writeback a pending one, commit a done one
      if (alloc_fire) begin
        busy[tail]   <= 1'b1;
        done[tail]   <= 1'b0;
        wr_q[tail]   <= rob.alloc_wr;
        addr_q[tail] <= rob.alloc_addr;
        tail         <= tail + 1'b1;
      end
      if (wb_fire) begin
        done[rob.wb_id]    <= 1'b1;
        value_q[rob.wb_id] <= rob.wb_value;
      end
      if (commit_fire) begin
        rob.commit_valid <= 1'b1;
        rob.commit_wr    <= wr_q[head];
        rob.commit_addr  <= addr_q[head];
        rob.commit_value <= value_q[head];
        busy[head]       <= 1'b0;
        done[head]       <= 1'b0;
        head             <= head + 1'b1;
      end else begin
        rob.commit_valid <= 1'b0;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Export pending entries to unavailable and completed entries to available
  always_comb begin
    rob.unavailable = '0;
    rob.available   = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (busy[i] && !done[i]) begin
        rob.unavailable[i] = {addr_q[i], wr_q[i], ID_SIZE'(i), 1'b1};
      end else if (busy[i] && done[i]) begin
        rob.available[i] = {value_q[i], addr_q[i], wr_q[i], ID_SIZE'(i), 1'b1};
      end
    end
  end
endmodule
